cache_coherence_controller: RTL
===============================

// Module: cache_coherence_controller
// PURPOSE
// - Shared-memory side of the per-core L1 cache interface. It answers cache misses from up to NCORES CPU cores.
// - Each core raises a miss; the controller arbitrates round-robin, stalls requesters and snoops the other caches.
// - It writes back a MODIFIED owner copy to SSRAM, fills the requester from SSRAM, and invalidates other copies on writes.
// - Sits between the CPU cores and the single shared SSRAM; it is the sole SSRAM master.
// PARAMETERS
// - NCORES   4   number of cores served (2..8)
// - AW       6   SSRAM word address width
// - DW       32  data width
// - SRAM_LAT 2   cycles from sram_oe asserted to sram_rd valid (1..7)
// PORTS
// - new_clock     in   1           system clock, all state on rising edge
// - reset         in   1           asynchronous, active-high reset
// - req_valid     in   NCORES      core i has an outstanding miss (level, held until ack)
// - req_we        in   NCORES      core i miss is a store (needs exclusive copy)
// - req_addr      in   NCORES*AW   miss address per core, stable while req_valid
// - core_stall    out  NCORES      stall to core i pipeline
// - ack           out  NCORES      1-cycle pulse: miss of core i finished
// - snoop_addr    out  AW          broadcast lookup address to all caches
// - snoop_state   in   NCORES*2    line state of snoop_addr per core (coh_state_t)
// - snoop_data    in   NCORES*DW   line data of snoop_addr per core
// - invalidate    out  NCORES      1-cycle pulse: core i drops line at snoop_addr
// - fill_data     out  DW          fill word for the requester
// - fill_valid    out  NCORES      1-cycle one-hot: core i writes fill_data into its cache
// - fill_state    out  2           state the filled line enters (SHARED / MODIFIED)
// - sram_addr     out  AW          SSRAM address
// - sram_wd       out  DW          SSRAM write data
// - sram_rd       in   DW          SSRAM read data
// - sram_gw       out  1           SSRAM global write enable, active-high
// - sram_oe       out  1           SSRAM output enable, active-high
// BEHAVIOUR
// - Reset (async): state IDLE, rr pointer 0; every output 0 (core_stall 0, ack 0, sram_gw/oe 0, fill_valid 0).
// - core_stall[i] = req_valid[i] & ~ack[i] (combinational); unserved requesters stay stalled.
// - FSM:
//   - IDLE: if any req_valid, grant the first requester at or after rr (wrapping), latch gnt/addr/we, go to SNOOP.
//   - SNOOP: snoop_addr = latched addr, 1 cycle. Sample snoop_state of all cores except the granted core.
//     - If any other core is MODIFIED (at most one by invariant), go to WB; otherwise go to RD.
//   - WB: sram_gw=1, sram_wd = owner snoop_data, sram_addr = addr, for 1 cycle, then go to RD.
//     - On a load the owner stays SHARED; no invalidate is issued.
//   - RD: sram_oe=1 for SRAM_LAT cycles (counter); capture sram_rd on the last cycle, then go to FILL.
//   - FILL: fill_valid[gnt]=1, fill_data = captured word, fill_state = we ? MODIFIED : SHARED.
//     - If we: invalidate[j]=1 for every j!=gnt whose sampled state != INVALID.
//     - ack[gnt]=1 in the same cycle; go to DONE.
//   - DONE: 1 cycle (lets req_valid drop), rr = gnt+1 mod NCORES, go to IDLE.
// - Latency for an uncontended miss: req_valid to ack = 3+SRAM_LAT cycles without WB, 4+SRAM_LAT with WB.
// - Upgrade (store hit on a SHARED line) uses the same path: the refetch is harmless and the invalidate is what matters.
// - req_valid dropping mid-transaction is illegal; the controller completes the transaction anyway.
// - A new req_valid arriving while busy waits; it is never lost, and fairness is guaranteed by rr.
// - Two cores reporting MODIFIED is an assertion failure; the lowest index is written back.
// - Reset mid-transaction aborts immediately: no partial sram_gw pulse survives past reset assertion.
// - rr wrap: rr = NCORES-1 then gnt+1 gives rr 0.
// STRUCTURE
// - Package coherence_pkg: typedef enum logic [1:0] coh_state_t {INVALID=0, SHARED=1, MODIFIED=2};
//   typedef enum ctrl_state_t {IDLE, SNOOP, WB, RD, FILL, DONE}; constant NCORES_MAX=8.
// - One sub-module: rr_arbiter (NCORES req vector + rr pointer -> one-hot grant + index), pure combinational.
// TESTING
// - Single load, core0 addr 6'h05, SRAM[5]=32'hDEADBEEF, others INVALID:
//   -> fill_valid=4'b0001, fill_data DEADBEEF, fill_state SHARED, ack at cycle 3+SRAM_LAT, no sram_gw.
// - Core1 store addr 6'h0A, core2 and core3 SHARED:
//   -> fill_state MODIFIED, invalidate=4'b1100 in FILL cycle, ack[1].
// - Core0 load addr 6'h0A, core1 MODIFIED with data 32'h12345678:
//   -> sram_gw 1 cycle (addr 0A, wd 12345678), then fill 12345678, no invalidate.
// - All four req_valid together, rr=0:
//   -> acks in order core0,1,2,3; each core_stall held until its own ack.
// - rr=3 with core0 and core3 requesting:
//   -> core3 served first, then core0 (wrap-around).
// - Assert reset during RD:
//   -> all outputs 0 asynchronously, state IDLE; after release the pending req_valid is re-granted and completes.

Source files
------------

// File: rtl/coherence_pkg.sv
// Shared types for the cache coherence controller: the per-line MSI state
// reported by each L1 and the controller's transaction state machine.
package coherence_pkg;

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        SHARED   = 2'd1,
        MODIFIED = 2'd2
    } coh_state_t;

    typedef enum logic [2:0] {
        IDLE,
        SNOOP,
        WB,
        RD,
        FILL,
        DONE
    } ctrl_state_t;

    localparam int NCORES_MAX = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: picks the first requester at or after the rr pointer,
// wrapping past the top index. Purely combinational.
module rr_arbiter #(
    parameter int NCORES = 4,
    parameter int IW     = $clog2(NCORES)
) (
    input  logic [NCORES-1:0] req,
    input  logic [IW-1:0]     rr,
    output logic [NCORES-1:0] gnt,
    output logic [IW-1:0]     gntIdx,
    output logic              any
);

    logic [IW-1:0] idx;
    logic          found;

    // Walk the cores starting at rr so the most recently served core goes last.
    always_comb begin
        gnt    = '0;
        gntIdx = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < NCORES; k++) begin
            idx = IW'((int'(rr) + k) % NCORES);
            if (!found && req[idx]) begin
                found    = 1'b1;
                gnt[idx] = 1'b1;
                gntIdx   = idx;
            end
        end
        any = found;
    end

endmodule

// File: rtl/cache_coherence_controller.sv
// Shared-memory side of the L1 miss interface. Serves one core miss at a time:
// snoop the other caches, write back a MODIFIED owner, refill the requester from
// SSRAM and, for stores, invalidate every other holder of the line.
module cache_coherence_controller
    import coherence_pkg::*;
#(
    parameter int NCORES   = 4,
    parameter int AW       = 6,
    parameter int DW       = 32,
    parameter int SRAM_LAT = 2
) (
    input  logic                 new_clock,
    input  logic                 reset,
    input  logic [NCORES-1:0]    req_valid,
    input  logic [NCORES-1:0]    req_we,
    input  logic [NCORES*AW-1:0] req_addr,
    output logic [NCORES-1:0]    core_stall,
    output logic [NCORES-1:0]    ack,
    output logic [AW-1:0]        snoop_addr,
    input  logic [NCORES*2-1:0]  snoop_state,
    input  logic [NCORES*DW-1:0] snoop_data,
    output logic [NCORES-1:0]    invalidate,
    output logic [DW-1:0]        fill_data,
    output logic [NCORES-1:0]    fill_valid,
    output logic [1:0]           fill_state,
    output logic [AW-1:0]        sram_addr,
    output logic [DW-1:0]        sram_wd,
    input  logic [DW-1:0]        sram_rd,
    output logic                 sram_gw,
    output logic                 sram_oe
);

    localparam int IW = $clog2(NCORES);
    localparam int CW = 3;

    ctrl_state_t       state_q, state_d;
    logic [NCORES-1:0] gnt_q, gnt_d;
    logic [IW-1:0]     gntIdx_q, gntIdx_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic              we_q, we_d;
    logic [IW-1:0]     rr_q, rr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DW-1:0]     rdData_q, rdData_d;
    logic [NCORES-1:0] sharers_q, sharers_d;
    logic [DW-1:0]     ownerData_q, ownerData_d;

    logic [NCORES-1:0] arbGnt;
    logic [IW-1:0]     arbIdx;
    logic              arbAny;

    logic [NCORES-1:0] otherMask;
    logic [NCORES-1:0] modMask;
    logic [DW-1:0]     ownerData;
    logic              ownerFound;
    coh_state_t        snoopSt;

    rr_arbiter #(
        .NCORES (NCORES),
        .IW     (IW)
    ) uArbiter (
        .req    (req_valid),
        .rr     (rr_q),
        .gnt    (arbGnt),
        .gntIdx (arbIdx),
        .any    (arbAny)
    );

    // Classify the other caches' copies; the lowest-index MODIFIED core is the owner.
    always_comb begin
        otherMask  = '0;
        modMask    = '0;
        ownerData  = '0;
        ownerFound = 1'b0;
        snoopSt    = INVALID;
        for (int i = 0; i < NCORES; i++) begin
            snoopSt = coh_state_t'(snoop_state[2*i +: 2]);
            if (!gnt_q[i]) begin
                if (snoopSt != INVALID) begin
                    otherMask[i] = 1'b1;
                end
                if (snoopSt == MODIFIED) begin
                    modMask[i] = 1'b1;
                    if (!ownerFound) begin
                        ownerFound = 1'b1;
                        ownerData  = snoop_data[DW*i +: DW];
                    end
                end
            end
        end
    end

    // Transaction sequencing and the registers each phase latches.
    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        gntIdx_d    = gntIdx_q;
        addr_d      = addr_q;
        we_d        = we_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        rdData_d    = rdData_q;
        sharers_d   = sharers_q;
        ownerData_d = ownerData_q;
        case (state_q)
            IDLE: begin
                if (arbAny) begin
                    gnt_d    = arbGnt;
                    gntIdx_d = arbIdx;
                    addr_d   = req_addr[arbIdx*AW +: AW];
                    we_d     = req_we[arbIdx];
                    state_d  = SNOOP;
                end
            end
            SNOOP: begin
                sharers_d   = otherMask;
                ownerData_d = ownerData;
                cnt_d       = '0;
                state_d     = (|modMask) ? WB : RD;
            end
            WB: begin
                state_d = RD;
            end
            RD: begin
                if (cnt_q == CW'(SRAM_LAT - 1)) begin
                    rdData_d = sram_rd;
                    state_d  = FILL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FILL: begin
                state_d = DONE;
            end
            DONE: begin
                rr_d    = (gntIdx_q == IW'(NCORES - 1)) ? '0 : gntIdx_q + 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge new_clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gntIdx_q    <= '0;
            addr_q      <= '0;
            we_q        <= 1'b0;
            rr_q        <= '0;
            cnt_q       <= '0;
            rdData_q    <= '0;
            sharers_q   <= '0;
            ownerData_q <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gntIdx_q    <= gntIdx_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            rdData_q    <= rdData_d;
            sharers_q   <= sharers_d;
            ownerData_q <= ownerData_d;
        end
    end

    // Moore outputs decoded from the current phase; everything idles at zero.
    always_comb begin
        snoop_addr = '0;
        sram_addr  = '0;
        sram_wd    = '0;
        sram_gw    = 1'b0;
        sram_oe    = 1'b0;
        fill_valid = '0;
        fill_data  = '0;
        fill_state = INVALID;
        ack        = '0;
        invalidate = '0;
        case (state_q)
            SNOOP: begin
                snoop_addr = addr_q;
            end
            WB: begin
                sram_gw   = 1'b1;
                sram_addr = addr_q;
                sram_wd   = ownerData_q;
            end
            RD: begin
                sram_oe   = 1'b1;
                sram_addr = addr_q;
            end
            FILL: begin
                fill_valid = gnt_q;
                fill_data  = rdData_q;
                fill_state = we_q ? MODIFIED : SHARED;
                ack        = gnt_q;
                invalidate = we_q ? sharers_q : '0;
            end
            default: begin
            end
        endcase
    end

    // Requesters stay stalled until their own ack; reset forces the stall low.
    always_comb begin
        core_stall = reset ? '0 : (req_valid & ~ack);
    end

    // The MSI invariant allows at most one MODIFIED copy besides the requester's.
    a_singleOwner : assert property (@(posedge new_clock) disable iff (reset)
        (state_q == SNOOP) |-> ($countones(modMask) <= 1));

    a_coreCount : assert property (@(posedge new_clock) disable iff (reset)
        (NCORES <= NCORES_MAX));

endmodule
